// File: rtl/serial_parity_rx.sv
// Receive end of the XOR parity link: start bit, DATA_W data bits LSB first,
// parity bit, stop bit, all sampled on bit_en strobes.
module serial_parity_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RESYNC
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               acc_q;
    logic               perr_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               parity_err_q;
    logic               frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // valid is a single-clock pulse regardless of strobe spacing
            valid_q <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_in) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            acc_q   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {rx_in, shift_q[DATA_W-1:1]};
                        acc_q   <= acc_q ^ rx_in;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        perr_q  <= acc_q ^ rx_in ^ 1'(ODD);
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        data_q       <= shift_q;
                        parity_err_q <= perr_q;
                        frame_err_q  <= ~rx_in;
                        valid_q      <= 1'b1;
                        // a low stop leaves the line low; wait for high before rearming
                        state_q      <= rx_in ? S_IDLE : S_RESYNC;
                    end
                    S_RESYNC: begin
                        if (rx_in) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
